// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter sharing the AHB-to-APB bridge slave port between NM
// AHB masters. Address-phase signals follow the registered owner, write data
// follows the data-phase owner, and a beat quantum bounds single-transfer runs.
module ahb_bridge_arbiter #(
   parameter int NM      = 4,
   parameter int MW      = 2,
   parameter int MAXBEAT = 8
) (
   input  logic             hclk,
   input  logic             hresetn,
   input  logic [NM-1:0]    hbusreq,
   input  logic [NM*32-1:0] haddr_m,
   input  logic [NM*2-1:0]  htrans_m,
   input  logic [NM-1:0]    hwrite_m,
   input  logic [NM*32-1:0] hwdata_m,
   input  logic             hready,
   output logic [NM-1:0]    hgrant,
   output logic [MW-1:0]    hmaster,
   output logic [MW-1:0]    hmaster_d,
   output logic [31:0]      haddr,
   output logic [1:0]       htrans,
   output logic             hwrite,
   output logic [31:0]      hwdata,
   output logic             hreadyin
);

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;
   localparam logic [7:0] MAXB      = 8'(MAXBEAT);

   // own_* tracks the address-phase owner, dat_* the data-phase owner
   logic [MW-1:0] own_q, own_d;
   logic [MW-1:0] dat_q, dat_d;
   logic [7:0]    beat_q, beat_d;

   int            own_idx;
   int            dat_idx;
   logic [1:0]    own_trans;
   logic [7:0]    beat_inc;
   logic          keep;
   logic          found;
   logic [MW-1:0] winner;

   // Owner indices and the owner's current transfer type
   always_comb begin
      own_idx   = 32'(own_q);
      dat_idx   = 32'(dat_q);
      own_trans = htrans_m[2*own_idx +: 2];
   end

   // Beat accounting and the retain-or-rotate decision for the current owner
   always_comb begin
      beat_inc = beat_q;
      if ((own_trans == HT_NONSEQ || own_trans == HT_SEQ) && beat_q < MAXB)
         beat_inc = beat_q + 8'd1;
      keep = (own_trans == HT_SEQ) || (own_trans == HT_BUSY) ||
             (hbusreq[own_idx] && beat_inc < MAXB);
   end

   // Round-robin search starting after the owner; the owner itself is tried last
   always_comb begin
      found  = 1'b0;
      winner = own_q;
      for (int k = 1; k <= NM; k++) begin
         if (!found && hbusreq[(own_idx + k) % NM]) begin
            found  = 1'b1;
            winner = MW'((own_idx + k) % NM);
         end
      end
   end

   // Next-state: everything holds during wait states, arbitration on hready
   always_comb begin
      own_d  = own_q;
      dat_d  = dat_q;
      beat_d = beat_q;
      if (hready) begin
         dat_d = own_q;
         if (keep) begin
            beat_d = beat_inc;
         end else if (!found) begin
            beat_d = '0;
         end else if (winner != own_q) begin
            own_d  = winner;
            beat_d = '0;
         end else begin
            // sole requester re-wins: restart its quantum once it is used up
            beat_d = (beat_inc == MAXB) ? '0 : beat_inc;
         end
      end
   end

   // Ownership and quantum registers, parked on master 0 after reset
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         own_q  <= '0;
         dat_q  <= '0;
         beat_q <= '0;
      end else begin
         own_q  <= own_d;
         dat_q  <= dat_d;
         beat_q <= beat_d;
      end
   end

   // Grant decode and bridge-side multiplexers
   always_comb begin
      hgrant          = '0;
      hgrant[own_idx] = 1'b1;
      hmaster         = own_q;
      hmaster_d       = dat_q;
      haddr           = haddr_m[32*own_idx +: 32];
      htrans          = htrans_m[2*own_idx +: 2];
      hwrite          = hwrite_m[own_idx];
      hwdata          = hwdata_m[32*dat_idx +: 32];
      hreadyin        = hready;
   end

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Directed bench for ahb_bridge_arbiter: a MAXBEAT=8 instance for most
// scenarios and a MAXBEAT=1 instance for plain round-robin rotation.
module tb_ahb_bridge_arbiter;

   localparam int NM = 4;
   localparam int MW = 2;

   logic             hclk = 1'b0;
   logic             hresetn;
   logic [NM-1:0]    hbusreq;
   logic [NM*32-1:0] haddr_m;
   logic [NM*2-1:0]  htrans_m;
   logic [NM-1:0]    hwrite_m;
   logic [NM*32-1:0] hwdata_m;
   logic             hready;

   logic [NM-1:0]    hgrant,    hgrant_r;
   logic [MW-1:0]    hmaster,   hmaster_r;
   logic [MW-1:0]    hmaster_d, hmaster_d_r;
   logic [31:0]      haddr,     haddr_r;
   logic [1:0]       htrans,    htrans_r;
   logic             hwrite,    hwrite_r;
   logic [31:0]      hwdata,    hwdata_r;
   logic             hreadyin,  hreadyin_r;

   int checks   = 0;
   int failures = 0;

   always #5 hclk = ~hclk;

   ahb_bridge_arbiter #(.NM(NM), .MW(MW), .MAXBEAT(8)) dut (
      .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .haddr_m(haddr_m),
      .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hwdata_m(hwdata_m),
      .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
      .hmaster_d(hmaster_d), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
      .hwdata(hwdata), .hreadyin(hreadyin)
   );

   ahb_bridge_arbiter #(.NM(NM), .MW(MW), .MAXBEAT(1)) dut_rr (
      .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .haddr_m(haddr_m),
      .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hwdata_m(hwdata_m),
      .hready(hready), .hgrant(hgrant_r), .hmaster(hmaster_r),
      .hmaster_d(hmaster_d_r), .haddr(haddr_r), .htrans(htrans_r),
      .hwrite(hwrite_r), .hwdata(hwdata_r), .hreadyin(hreadyin_r)
   );

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge
   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic set_m(input int i, input logic [31:0] addr,
                        input logic [1:0] trans, input logic wr,
                        input logic [31:0] wdata);
      haddr_m[32*i +: 32]  = addr;
      htrans_m[2*i +: 2]   = trans;
      hwrite_m[i]          = wr;
      hwdata_m[32*i +: 32] = wdata;
   endtask

   task automatic all_idle();
      hbusreq = '0;
      for (int i = 0; i < NM; i++) set_m(i, 32'h0, 2'b00, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      step();
   endtask

   initial begin
      hready = 1'b1;
      all_idle();

      // Reset held for two cycles with everyone requesting
      hresetn = 1'b0;
      hbusreq = 4'b1111;
      for (int i = 0; i < NM; i++) set_m(i, 32'h100 * i, 2'b10, 1'b0, 32'h0);
      for (int c = 0; c < 2; c++) begin
         step();
         check_val("rst_hgrant",    32'(hgrant),    32'h1);
         check_val("rst_hmaster",   32'(hmaster),   32'h0);
         check_val("rst_hmaster_d", 32'(hmaster_d), 32'h0);
      end

      // Single requester: master 2
      all_idle();
      hbusreq = 4'b0100;
      set_m(2, 32'h8000_0010, 2'b10, 1'b1, 32'hA5A5_0001);
      hresetn = 1'b1;
      step();
      check_val("single_hgrant", 32'(hgrant), 32'h4);
      check_val("single_haddr",  haddr,       32'h8000_0010);
      check_val("single_htrans", 32'(htrans), 32'h2);
      check_val("single_hwrite", 32'(hwrite), 32'h1);
      set_m(2, 32'h8000_0014, 2'b00, 1'b0, 32'hA5A5_0001);
      hbusreq = 4'b0000;
      step();
      check_val("single_hmaster_d", 32'(hmaster_d), 32'h2);
      check_val("single_hwdata",    hwdata,         32'hA5A5_0001);
      step();
      check_val("park_hmaster", 32'(hmaster), 32'h2);
      check_val("park_hgrant",  32'(hgrant),  32'h4);

      // Round-robin with MAXBEAT=1: 0,1,2,3,0
      do_reset();
      hbusreq = 4'b1111;
      for (int i = 0; i < NM; i++) set_m(i, 32'h100 * i, 2'b10, 1'b0, 32'h0);
      check_val("rr_start", 32'(hmaster_r), 32'h0);
      hresetn = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         check_val("rr_hmaster", 32'(hmaster_r), 32'(c % NM));
      end

      // Burst hold: master 1 INCR8 while master 3 waits
      all_idle();
      do_reset();
      hbusreq = 4'b1010;
      hresetn = 1'b1;
      step();
      check_val("burst_grant1", 32'(hmaster), 32'h1);
      for (int b = 1; b <= 8; b++) begin
         set_m(1, 32'h2000 + 32'(4 * b), (b == 1) ? 2'b10 : 2'b11, 1'b1, 32'h0);
         step();
         check_val("burst_hold", 32'(hmaster), 32'h1);
      end
      set_m(1, 32'h0, 2'b00, 1'b0, 32'h0);
      hbusreq = 4'b1000;
      step();
      check_val("burst_handover", 32'(hmaster), 32'h3);
      check_val("burst_hgrant",   32'(hgrant),  32'h8);

      // Quantum: master 0 singles, master 2 waiting, MAXBEAT=8
      all_idle();
      do_reset();
      hbusreq = 4'b0101;
      set_m(0, 32'h3000, 2'b10, 1'b0, 32'h0);
      hresetn = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         step();
         check_val("quant_hold", 32'(hmaster), 32'h0);
      end
      step();
      check_val("quant_handover", 32'(hmaster), 32'h2);

      // Wait states on the last beat of master 1's write before handover
      all_idle();
      do_reset();
      hbusreq = 4'b1010;
      hresetn = 1'b1;
      step();
      check_val("ws_grant1", 32'(hmaster), 32'h1);
      set_m(1, 32'h4000, 2'b10, 1'b1, 32'h0);
      step();
      check_val("ws_hmaster_d", 32'(hmaster_d), 32'h1);
      set_m(1, 32'h0, 2'b00, 1'b0, 32'h1234_5678);
      hbusreq = 4'b1000;
      hready  = 1'b0;
      for (int w = 0; w < 3; w++) begin
         step();
         check_val("ws_hmaster",   32'(hmaster),   32'h1);
         check_val("ws_hmaster_d", 32'(hmaster_d), 32'h1);
         check_val("ws_hwdata",    hwdata,         32'h1234_5678);
         check_val("ws_hreadyin",  32'(hreadyin),  32'h0);
      end
      hready = 1'b1;
      step();
      check_val("ws_handover",   32'(hmaster),   32'h3);
      check_val("ws_data_owner", 32'(hmaster_d), 32'h1);
      check_val("ws_hreadyin1",  32'(hreadyin),  32'h1);
      step();
      check_val("ws_data_owner3", 32'(hmaster_d), 32'h3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
